// File: rtl/zynet_axil_regs.sv
// AXI4-Lite responder and register file for the zyNet core: weight/bias load strobes,
// layer/neuron selection, result capture, final-layer readback and completion interrupt.
module zynet_axil_regs #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 5,
  parameter int dataWidth          = 16,
  parameter int numOut             = 10
) (
  input  logic                              s_axi_aclk,
  input  logic                              s_axi_aresetn,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]     s_axi_awaddr,
  input  logic                              s_axi_awvalid,
  output logic                              s_axi_awready,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]     s_axi_wdata,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   s_axi_wstrb,
  input  logic                              s_axi_wvalid,
  output logic                              s_axi_wready,
  output logic [1:0]                        s_axi_bresp,
  output logic                              s_axi_bvalid,
  input  logic                              s_axi_bready,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]     s_axi_araddr,
  input  logic                              s_axi_arvalid,
  output logic                              s_axi_arready,
  output logic [C_S_AXI_DATA_WIDTH-1:0]     s_axi_rdata,
  output logic [1:0]                        s_axi_rresp,
  output logic                              s_axi_rvalid,
  input  logic                              s_axi_rready,
  output logic                              weightValid,
  output logic [dataWidth-1:0]              weightValue,
  output logic                              biasValid,
  output logic [dataWidth-1:0]              biasValue,
  output logic [31:0]                       config_layer_num,
  output logic [31:0]                       config_neuron_num,
  output logic                              softReset,
  input  logic [31:0]                       out,
  input  logic                              out_valid,
  input  logic [numOut*dataWidth-1:0]       nn_out,
  output logic                              intr
);

  localparam int IDX_W = (numOut > 1) ? $clog2(numOut) : 1;

  typedef enum logic [1:0] {W_IDLE, W_ACK, W_RESP} w_state_t;
  typedef enum logic [1:0] {R_IDLE, R_ACK, R_DATA} r_state_t;

  w_state_t w_state, w_next;
  r_state_t r_state, r_next;

  logic [2:0]                    wr_sel;
  logic [2:0]                    rd_sel;
  logic                          wr_fire;
  logic                          rd_done;
  logic                          result_ready;
  logic [31:0]                   result_reg;
  logic [IDX_W-1:0]              idx;
  logic [dataWidth-1:0]          nn_slice;
  logic [C_S_AXI_DATA_WIDTH-1:0] rd_mux;
  logic                          unused_addr_lsbs;

  assign unused_addr_lsbs = ^{s_axi_awaddr[1:0], s_axi_araddr[1:0]};

  assign wr_sel      = s_axi_awaddr[4:2];
  assign wr_fire     = (w_state == W_ACK);
  assign rd_done     = (r_state == R_DATA) && s_axi_rready;
  assign s_axi_bresp = 2'b00;
  assign s_axi_rresp = 2'b00;
  assign intr        = result_ready;

  function automatic logic [31:0] apply_strb(input logic [31:0] old_val,
                                             input logic [31:0] new_val,
                                             input logic [3:0]  strb);
    logic [31:0] res;
    res = old_val;
    for (int b = 0; b < 4; b++)
      if (strb[b]) res[8*b +: 8] = new_val[8*b +: 8];
    return res;
  endfunction

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge s_axi_aclk) begin
    if (!s_axi_aresetn) begin
      w_state <= W_IDLE;
      r_state <= R_IDLE;
    end else begin
      w_state <= w_next;
      r_state <= r_next;
    end
  end

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    w_next        = w_state;
    s_axi_awready = 1'b0;
    s_axi_wready  = 1'b0;
    s_axi_bvalid  = 1'b0;
    case (w_state)
      W_IDLE: if (s_axi_awvalid && s_axi_wvalid) w_next = W_ACK;
      W_ACK: begin
        s_axi_awready = 1'b1;
        s_axi_wready  = 1'b1;
        w_next        = W_RESP;
      end
      W_RESP: begin
        s_axi_bvalid = 1'b1;
        if (s_axi_bready) w_next = W_IDLE;
      end
      default: w_next = W_IDLE;
    endcase
  end

  always_comb begin
    r_next        = r_state;
    s_axi_arready = 1'b0;
    s_axi_rvalid  = 1'b0;
    case (r_state)
      R_IDLE: if (s_axi_arvalid) r_next = R_ACK;
      R_ACK: begin
        s_axi_arready = 1'b1;
        r_next        = R_DATA;
      end
      R_DATA: begin
        s_axi_rvalid = 1'b1;
        if (s_axi_rready) r_next = R_IDLE;
      end
      default: r_next = R_IDLE;
    endcase
  end

  // Write side: strobes are cleared every cycle so they can never stretch past one clock.
  always_ff @(posedge s_axi_aclk) begin
    if (!s_axi_aresetn) begin
      weightValid       <= 1'b0;
      weightValue       <= '0;
      biasValid         <= 1'b0;
      biasValue         <= '0;
      config_layer_num  <= '0;
      config_neuron_num <= '0;
      softReset         <= 1'b1;
    end else begin
      weightValid <= 1'b0;
      biasValid   <= 1'b0;
      if (wr_fire) begin
        case (wr_sel)
          3'd0: begin
            weightValid <= 1'b1;
            weightValue <= s_axi_wdata[dataWidth-1:0];
          end
          3'd1: begin
            biasValid <= 1'b1;
            biasValue <= s_axi_wdata[dataWidth-1:0];
          end
          3'd3: config_layer_num  <= apply_strb(config_layer_num, s_axi_wdata, s_axi_wstrb);
          3'd4: config_neuron_num <= apply_strb(config_neuron_num, s_axi_wdata, s_axi_wstrb);
          3'd7: if (s_axi_wstrb[0]) softReset <= s_axi_wdata[0];
          default: ;
        endcase
      end
    end
  end

  // Set has priority over both clear sources.
  always_ff @(posedge s_axi_aclk) begin
    if (!s_axi_aresetn) begin
      result_reg   <= '0;
      result_ready <= 1'b0;
      idx          <= '0;
    end else begin
      if (out_valid) begin
        result_reg   <= out;
        result_ready <= 1'b1;
      end else if (softReset || (rd_done && rd_sel == 3'd2)) begin
        result_ready <= 1'b0;
      end
      if (out_valid)
        idx <= '0;
      else if (rd_done && rd_sel == 3'd5)
        idx <= (idx == IDX_W'(numOut - 1)) ? '0 : idx + 1'b1;
    end
  end

  assign nn_slice = nn_out[int'(idx)*dataWidth +: dataWidth];

  always_comb begin
    rd_mux = '0;
    case (s_axi_araddr[4:2])
      3'd2: rd_mux = result_reg;
      3'd3: rd_mux = config_layer_num;
      3'd4: rd_mux = config_neuron_num;
      3'd5: rd_mux = C_S_AXI_DATA_WIDTH'($signed(nn_slice));
      3'd6: rd_mux = C_S_AXI_DATA_WIDTH'({softReset, result_ready});
      3'd7: rd_mux = C_S_AXI_DATA_WIDTH'(softReset);
      default: rd_mux = '0;
    endcase
  end

  // Read data is frozen at the R_ACK edge and held through R_DATA.
  always_ff @(posedge s_axi_aclk) begin
    if (!s_axi_aresetn) begin
      rd_sel      <= '0;
      s_axi_rdata <= '0;
    end else if (r_state == R_ACK) begin
      rd_sel      <= s_axi_araddr[4:2];
      s_axi_rdata <= rd_mux;
    end
  end

endmodule
